// File: rtl/scariv_brtag_alloc_if.sv
// Dispatch / commit / BRU-update bundle for the branch-tag allocator.
// The master drives requests, and the allocator (slave) returns tags and ready.
interface scariv_brtag_alloc_if #(
  parameter int ENTRY_SIZE = 16,
  parameter int DISP_SIZE  = 4,
  parameter int TAG_W      = $clog2(ENTRY_SIZE)
);
  logic [DISP_SIZE-1:0]            i_disp_valid;
  logic                            i_disp_fire;
  logic                            o_brtag_ready;
  logic [DISP_SIZE-1:0][TAG_W-1:0] o_brtag;

  logic                            i_cmt_commit;
  logic [DISP_SIZE-1:0]            i_cmt_is_br_inst;
  logic                            i_cmt_dead;

  logic                            i_br_upd_update;
  logic                            i_br_upd_mispredict;
  logic                            i_br_upd_dead;
  logic [TAG_W-1:0]                i_br_upd_brtag;

  logic                            i_flush_all;

  modport master (
    output i_disp_valid, i_disp_fire,
    output i_cmt_commit, i_cmt_is_br_inst, i_cmt_dead,
    output i_br_upd_update, i_br_upd_mispredict, i_br_upd_dead, i_br_upd_brtag,
    output i_flush_all,
    input  o_brtag_ready, o_brtag
  );

  modport slave (
    input  i_disp_valid, i_disp_fire,
    input  i_cmt_commit, i_cmt_is_br_inst, i_cmt_dead,
    input  i_br_upd_update, i_br_upd_mispredict, i_br_upd_dead, i_br_upd_brtag,
    input  i_flush_all,
    output o_brtag_ready, o_brtag
  );
endinterface

// File: rtl/scariv_brtag_alloc.sv
// Branch-tag circular allocator: in-order allocate at dispatch, free at commit, rollback on mispredict.
// Optional protocol checker enabled by defining SCARIV_BRTAG_CHECK_EN.
module scariv_brtag_alloc #(
  parameter int ENTRY_SIZE = 16,
  parameter int DISP_SIZE  = 4,
  parameter int TAG_W      = $clog2(ENTRY_SIZE)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  scariv_brtag_alloc_if.slave      bus,
  output logic [TAG_W:0]           o_free_count,
  output logic [ENTRY_SIZE-1:0]    o_live_mask,
  output logic                     o_check_err
);

  localparam int PTR_W = TAG_W + 1;
  typedef logic [PTR_W-1:0] ptr_t;

  function automatic ptr_t popcount(input logic [DISP_SIZE-1:0] v);
    ptr_t c;
    c = '0;
    for (int i = 0; i < DISP_SIZE; i++) c = c + ptr_t'(v[i]);
    return c;
  endfunction

  ptr_t                            head_q, tail_q, head_d, tail_d;
  ptr_t                            occ_q, occ_d, disp_cnt, cmt_cnt;
  logic [ENTRY_SIZE-1:0]           live_q, live_d;
  logic [DISP_SIZE-1:0][TAG_W-1:0] brtag;
  logic [TAG_W-1:0]                off;
  ptr_t                            prefix;
  logic                            ready, alloc_en, free_en, mispred_req, rollback_en, rb_wrap;

  assign occ_q        = tail_q - head_q;
  assign o_free_count = ptr_t'(ENTRY_SIZE) - occ_q;
  assign disp_cnt     = popcount(bus.i_disp_valid);
  assign cmt_cnt      = popcount(bus.i_cmt_is_br_inst);
  assign ready        = disp_cnt <= o_free_count;

  assign free_en      = bus.i_cmt_commit & ~bus.i_cmt_dead;
  assign mispred_req  = bus.i_br_upd_update & bus.i_br_upd_mispredict & ~bus.i_br_upd_dead;
  // Liveness is read from the registered mask, which mirrors the current head/tail.
  assign rollback_en  = mispred_req & live_q[bus.i_br_upd_brtag];
  // A mispredict squashes the dispatch group fired in the same cycle.
  assign alloc_en     = bus.i_disp_fire & ready & ~mispred_req;
  // The branch is older than tail, so it wraps past head's index only if it is numerically below it.
  assign rb_wrap      = head_q[TAG_W] ^ (bus.i_br_upd_brtag < head_q[TAG_W-1:0]);

  assign bus.o_brtag_ready = ready;
  assign bus.o_brtag       = brtag;
  assign o_live_mask       = live_q;

  // NOTE: every variable written here gets a value before any branch, so no latch can be inferred.
  always_comb begin
    prefix = '0;
    for (int i = 0; i < DISP_SIZE; i++) begin
      brtag[i] = tail_q[TAG_W-1:0] + prefix[TAG_W-1:0];
      prefix   = prefix + ptr_t'(bus.i_disp_valid[i]);
    end
  end

  always_comb begin
    head_d = head_q + (free_en ? cmt_cnt : ptr_t'(0));
    tail_d = tail_q;
    if (bus.i_flush_all)  tail_d = head_d;
    else if (rollback_en) tail_d = {rb_wrap, bus.i_br_upd_brtag} + ptr_t'(1);
    else if (alloc_en)    tail_d = tail_q + disp_cnt;

    occ_d  = tail_d - head_d;
    off    = '0;
    live_d = '0;
    for (int t = 0; t < ENTRY_SIZE; t++) begin
      off       = TAG_W'(t) - head_d[TAG_W-1:0];
      live_d[t] = {1'b0, off} < occ_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      head_q <= '0;
      tail_q <= '0;
      live_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      live_q <= live_d;
    end
  end

`ifdef SCARIV_BRTAG_CHECK_EN
  logic err_fire, err_cmt, err_mis, err_any, check_err_q;

  assign err_fire = bus.i_disp_fire & ~ready & (|bus.i_disp_valid);
  assign err_cmt  = free_en & (cmt_cnt > occ_q);
  assign err_mis  = mispred_req & ~live_q[bus.i_br_upd_brtag];
  assign err_any  = err_fire | err_cmt | err_mis;

  always_ff @(posedge i_clk) begin
    if (i_reset) check_err_q <= 1'b0;
    else         check_err_q <= check_err_q | err_any;
  end

  assign o_check_err = check_err_q;

`ifdef SIMULATION
  always_ff @(posedge i_clk) begin
    if (!i_reset && err_any)
      $error("brtag protocol error: fire=%0b commit=%0b mispredict=%0b", err_fire, err_cmt, err_mis);
  end
`endif
`else
  assign o_check_err = 1'b0;
`endif

endmodule

// File: tb/tb_scariv_brtag_alloc.sv
// Directed bench for scariv_brtag_alloc: a tag-queue model checked every cycle plus literal pins.
module tb_scariv_brtag_alloc;

  localparam int N = 16;
  localparam int D = 4;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W:0]    free_count;
  logic [N-1:0]  live_mask;
  logic          check_err;

  int n_checks = 0;
  int n_fail   = 0;

  scariv_brtag_alloc_if #(.ENTRY_SIZE(N), .DISP_SIZE(D)) bus ();

  scariv_brtag_alloc #(.ENTRY_SIZE(N), .DISP_SIZE(D)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .bus          (bus),
    .o_free_count (free_count),
    .o_live_mask  (live_mask),
    .o_check_err  (check_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: live tags in allocation order, plus the tag that is next to be freed.
  int q[$];
  int hd  = 0;
  bit err = 0;

  function automatic int next_tag();
    return (hd + q.size()) % N;
  endfunction

  function automatic bit is_live(input int t);
    foreach (q[k]) if (q[k] == t) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    int  pop, cpop, b, nt;
    bit  misp, live_b, rdy, free_ok;
    if (rst) begin
      q.delete();
      hd  = 0;
      err = 0;
    end else begin
      pop     = $countones(bus.i_disp_valid);
      cpop    = $countones(bus.i_cmt_is_br_inst);
      rdy     = pop <= (N - q.size());
      free_ok = bus.i_cmt_commit && !bus.i_cmt_dead;
      misp    = bus.i_br_upd_update && bus.i_br_upd_mispredict && !bus.i_br_upd_dead;
      b       = int'(bus.i_br_upd_brtag);
      live_b  = is_live(b);
`ifdef SCARIV_BRTAG_CHECK_EN
      if ((bus.i_disp_fire && !rdy && pop != 0) || (free_ok && cpop > q.size()) || (misp && !live_b))
        err = 1'b1;
`endif
      nt = next_tag();
      if (bus.i_flush_all) begin
      end else if (misp && live_b) begin
        while (q[$] != b) void'(q.pop_back());
      end else if (!misp && bus.i_disp_fire && rdy) begin
        for (int k = 0; k < pop; k++) q.push_back((nt + k) % N);
      end
      if (free_ok) begin
        for (int k = 0; k < cpop; k++) begin
          if (q.size() > 0) void'(q.pop_front());
          hd = (hd + 1) % N;
        end
      end
      if (bus.i_flush_all) q.delete();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [N-1:0] exp_live;
    int           pre;
    if (!rst) begin
      exp_live = '0;
      foreach (q[k]) exp_live[q[k]] = 1'b1;
      check("free_count", 64'(free_count), 64'(N - q.size()));
      check("live_mask", 64'(live_mask), 64'(exp_live));
      check("ready", 64'(bus.o_brtag_ready), 64'($countones(bus.i_disp_valid) <= (N - q.size())));
      check("check_err", 64'(check_err), 64'(err));
      pre = 0;
      for (int i = 0; i < D; i++) begin
        if (bus.i_disp_valid[i]) begin
          check($sformatf("brtag[%0d]", i), 64'(bus.o_brtag[i]), 64'((next_tag() + pre) % N));
          pre++;
        end
      end
    end
  end

  task automatic drive(input logic [3:0] dv, input logic fire, input logic [3:0] cmt,
                       input logic cdead, input logic mis, input logic [3:0] tag, input logic flush);
    bus.i_disp_valid        = dv;
    bus.i_disp_fire         = fire;
    bus.i_cmt_commit        = |cmt;
    bus.i_cmt_is_br_inst    = cmt;
    bus.i_cmt_dead          = cdead;
    bus.i_br_upd_update     = mis;
    bus.i_br_upd_mispredict = mis;
    bus.i_br_upd_dead       = 1'b0;
    bus.i_br_upd_brtag      = tag;
    bus.i_flush_all         = flush;
  endtask

  task automatic idle();
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset free", 64'(free_count), 64'd16);
    check("reset live", 64'(live_mask), 64'h0);
    check("reset ready", 64'(bus.o_brtag_ready), 64'd1);
    check("reset brtag", 64'(bus.o_brtag), 64'h0);
    check("reset err", 64'(check_err), 64'd0);

    // First group with a hole in slot 2.
    drive(4'b1011, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    check("t1 slot0", 64'(bus.o_brtag[0]), 64'd0);
    check("t1 slot1", 64'(bus.o_brtag[1]), 64'd1);
    check("t1 slot3", 64'(bus.o_brtag[3]), 64'd2);
    tick();
    idle();
    #1;
    check("t1 free", 64'(free_count), 64'd13);
    check("t1 live", 64'(live_mask), 64'h0007);

    // Fill to 15, then a 2-tag group must stall.
    repeat (3) begin
      drive(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
      tick();
    end
    drive(4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    check("full ready", 64'(bus.o_brtag_ready), 64'd0);
    tick();
    idle();
    #1;
    check("full free", 64'(free_count), 64'd1);
    check("full tail", 64'(bus.o_brtag[0]), 64'd15);
    drive(4'b0000, 1'b0, 4'b0011, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    drive(4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    check("commit free", 64'(free_count), 64'd3);
    check("commit ready", 64'(bus.o_brtag_ready), 64'd1);
    tick();

    // Flush with nothing committing: tail snaps back to head (2).
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b1);
    tick();
    idle();
    #1;
    check("flush free", 64'(free_count), 64'd16);
    check("flush tail", 64'(bus.o_brtag[0]), 64'd2);

    // Advance head and tail together to 14, overlapping fire and commit.
    drive(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    repeat (2) begin
      drive(4'b1111, 1'b1, 4'b1111, 1'b0, 1'b0, 4'd0, 1'b0);
      tick();
    end
    drive(4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    idle();
    #1;
    check("pre-wrap free", 64'(free_count), 64'd16);
    check("pre-wrap tail", 64'(bus.o_brtag[0]), 64'd14);

    // Wrap-around allocation.
    drive(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    check("wrap tags", 64'(bus.o_brtag), 64'h10FE);
    tick();
    idle();
    #1;
    check("wrap live", 64'(live_mask), 64'hC003);
    check("wrap free", 64'(free_count), 64'd12);
    check("wrap tail", 64'(bus.o_brtag[0]), 64'd2);

    // Build live tags 3..9.
    drive(4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    drive(4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    drive(4'b1111, 1'b1, 4'b0001, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    drive(4'b0111, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    idle();
    #1;
    check("3..9 live", 64'(live_mask), 64'h03F8);

    // Dead update, correct prediction and dead commit all leave state alone.
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'd4, 1'b0);
    bus.i_br_upd_dead = 1'b1;
    tick();
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd3, 1'b0);
    bus.i_br_upd_update = 1'b1;
    tick();
    drive(4'b0000, 1'b0, 4'b0011, 1'b1, 1'b0, 4'd0, 1'b0);
    tick();
    idle();
    #1;
    check("no-op free", 64'(free_count), 64'd9);

    // Mispredict on tag 5 together with a fire of 2.
    drive(4'b0011, 1'b1, 4'b0000, 1'b0, 1'b1, 4'd5, 1'b0);
    tick();
    idle();
    #1;
    check("misp free", 64'(free_count), 64'd13);
    check("misp live", 64'(live_mask), 64'h0038);
    check("misp tail", 64'(bus.o_brtag[0]), 64'd6);

    // Reset mid-operation.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid-reset free", 64'(free_count), 64'd16);
    check("mid-reset live", 64'(live_mask), 64'h0);

    // Live tags 2..6, then flush + mispredict + commit of one.
    drive(4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    drive(4'b1111, 1'b1, 4'b0011, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    drive(4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    idle();
    #1;
    check("2..6 live", 64'(live_mask), 64'h007C);
    drive(4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 4'd4, 1'b1);
    tick();
    idle();
    #1;
    check("flush+cmt free", 64'(free_count), 64'd16);
    check("flush+cmt tail", 64'(bus.o_brtag[0]), 64'd3);
    check("flush+cmt live", 64'(live_mask), 64'h0);

`ifdef SCARIV_BRTAG_CHECK_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'd12, 1'b0);
    tick();
    idle();
    #1;
    check("bad misp err", 64'(check_err), 64'd1);
    check("bad misp free", 64'(free_count), 64'd12);
    check("bad misp tail", 64'(bus.o_brtag[0]), 64'd4);
    tick();
    #1;
    check("err sticky", 64'(check_err), 64'd1);
`endif

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
